// File: rtl/serial_cfg_pkg.sv
// Shared types and field layout for the backend serial configuration link.
package serial_cfg_pkg;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, TAIL} state_t;

  localparam int CFG_WIDTH   = 5;
  localparam int GAIN_A1_LSB = 0;
  localparam int GAIN_A1_W   = 3;
  localparam int GAIN_A2_LSB = 3;
  localparam int GAIN_A2_W   = 2;

  function automatic logic [CFG_WIDTH-1:0] pack_gains(
    input logic [GAIN_A2_W-1:0] a2,
    input logic [GAIN_A1_W-1:0] a1
  );
    return {a2, a1};
  endfunction

endpackage

// File: rtl/sclk_divider.sv
// Phase counter: one-cycle phase_end every CLK_DIV cycles while en, cleared otherwise.
module sclk_divider #(
  parameter int CLK_DIV = 4
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic en,
  output logic phase_end
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign phase_end = en && (cnt == LAST);

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)                cnt <= '0;
    else if (!en || phase_end)  cnt <= '0;
    else                        cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/serial_cfg_tx.sv
// Shifts a parallel config word MSB-first over sclk/sdin with a start/busy/done handshake.
module serial_cfg_tx
  import serial_cfg_pkg::*;
#(
  parameter int WIDTH   = CFG_WIDTH,
  parameter int CLK_DIV = 4
) (
  input  logic             i_clk,
  input  logic             i_resetbAll,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_sclk,
  output logic             o_sdin
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  generate
    if (CLK_DIV < 2) begin : g_bad_div
      $error("serial_cfg_tx: CLK_DIV must be >= 2");
    end
  endgenerate

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [IW-1:0]    idx;
  logic             run;
  logic             phase_end;

  assign run = (state != IDLE);

  sclk_divider #(.CLK_DIV(CLK_DIV)) u_div (
    .gclk      (i_clk),
    .grst_n    (i_resetbAll),
    .en        (run),
    .phase_end (phase_end)
  );

  // sdin is loaded one phase ahead so it is already valid for the whole LOW phase.
  always_ff @(posedge i_clk or negedge i_resetbAll) begin
    if (!i_resetbAll) begin
      state  <= IDLE;
      shreg  <= '0;
      idx    <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_sclk <= 1'b0;
      o_sdin <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: if (i_start) begin
          shreg  <= i_data;
          idx    <= IW'(WIDTH - 1);
          o_sdin <= i_data[WIDTH-1];
          o_busy <= 1'b1;
          state  <= LOW;
        end
        LOW: if (phase_end) begin
          o_sclk <= 1'b1;
          state  <= HIGH;
        end
        HIGH: if (phase_end) begin
          o_sclk <= 1'b0;
          if (idx == '0) begin
            o_sdin <= 1'b0;
            state  <= TAIL;
          end else begin
            idx    <= idx - 1'b1;
            o_sdin <= shreg[idx - 1'b1];
            state  <= LOW;
          end
        end
        TAIL: if (phase_end) begin
          o_busy <= 1'b0;
          o_done <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_cfg_tx.sv
// Directed bench: three transmitters (CLK_DIV 2/4/7) with edge monitors and a backend receiver model.
module tb_serial_cfg_tx;
  import serial_cfg_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [2:0] st;
  logic [4:0] dat [3];
  logic [2:0] busy, done, sclk, sdin;
  logic       clr;

  int n_tests = 0;
  int n_fail  = 0;

  serial_cfg_tx #(.WIDTH(5), .CLK_DIV(2)) dut2 (
    .i_clk(clk), .i_resetbAll(rst_n), .i_start(st[0]), .i_data(dat[0]),
    .o_busy(busy[0]), .o_done(done[0]), .o_sclk(sclk[0]), .o_sdin(sdin[0]));
  serial_cfg_tx dut4 (
    .i_clk(clk), .i_resetbAll(rst_n), .i_start(st[1]), .i_data(dat[1]),
    .o_busy(busy[1]), .o_done(done[1]), .o_sclk(sclk[1]), .o_sdin(sdin[1]));
  serial_cfg_tx #(.WIDTH(5), .CLK_DIV(7)) dut7 (
    .i_clk(clk), .i_resetbAll(rst_n), .i_start(st[2]), .i_data(dat[2]),
    .o_busy(busy[2]), .o_done(done[2]), .o_sclk(sclk[2]), .o_sdin(sdin[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-instance monitors; cycle 1 is the first cycle busy is seen high.
  int ecnt = 0;
  int rises[3], busy_n[3], done_n[3], frames[3], b2b[3], viol[3];
  int base[3], first_rise[3], last_rise[3], done_cyc[3];
  logic [15:0] cap [3];
  logic psclk[3], psdin[3], pbusy[3], pdone[3];

  always @(posedge clk) ecnt <= ecnt + 1;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (clr) begin
        rises[i] <= 0; busy_n[i] <= 0; done_n[i] <= 0; frames[i] <= 0;
        b2b[i] <= 0; viol[i] <= 0; cap[i] <= '0;
        first_rise[i] <= 0; last_rise[i] <= 0; done_cyc[i] <= 0;
      end else begin
        if (busy[i] && !pbusy[i]) begin
          frames[i] <= frames[i] + 1;
          base[i]   <= ecnt;
          if (pdone[i]) b2b[i] <= b2b[i] + 1;
        end
        if (busy[i]) busy_n[i] <= busy_n[i] + 1;
        if (sclk[i] && !psclk[i]) begin
          rises[i] <= rises[i] + 1;
          cap[i]   <= {cap[i][14:0], sdin[i]};
          if (rises[i] == 0) first_rise[i] <= ecnt - base[i] + 1;
          last_rise[i] <= ecnt - base[i] + 1;
        end
        if (done[i]) begin
          done_n[i]   <= done_n[i] + 1;
          done_cyc[i] <= ecnt - base[i] + 1;
        end
        if (psclk[i] && sclk[i] && (sdin[i] != psdin[i])) viol[i] <= viol[i] + 1;
      end
      psclk[i] <= sclk[i]; psdin[i] <= sdin[i];
      pbusy[i] <= busy[i]; pdone[i] <= done[i];
    end
  end

  // Backend receiver model on the CLK_DIV=4 instance: rising-edge detect in the clk domain.
  logic [3:0] bk_sh;
  logic [4:0] bk_word;
  int         bk_cnt;
  logic       bk_prev;
  logic [GAIN_A1_W-1:0] gain_a1;
  logic [GAIN_A2_W-1:0] gain_a2;

  assign bk_word = {bk_sh, sdin[1]};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bk_sh <= '0; bk_cnt <= 0; bk_prev <= 1'b0; gain_a1 <= '0; gain_a2 <= '0;
    end else begin
      bk_prev <= sclk[1];
      if (sclk[1] && !bk_prev) begin
        bk_sh  <= bk_word[3:0];
        bk_cnt <= bk_cnt + 1;
        if (bk_cnt == CFG_WIDTH - 1) begin
          gain_a1 <= bk_word[GAIN_A1_LSB +: GAIN_A1_W];
          gain_a2 <= bk_word[GAIN_A2_LSB +: GAIN_A2_W];
        end
      end
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_mon();
    clr = 1'b1; step(); clr = 1'b0;
  endtask

  task automatic start_frame(input int i, input logic [4:0] d);
    st[i] = 1'b1; dat[i] = d; step(); st[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int n, input int budget);
    int k = 0;
    while (done_n[i] < n && k < budget) begin step(); k++; end
    if (done_n[i] < n) chk("timeout_done", done_n[i], n);
  endtask

  initial begin
    rst_n = 1'b0; st = '0; clr = 1'b0;
    for (int i = 0; i < 3; i++) dat[i] = '0;
    #12;
    chk("rst_busy", int'(busy[0]), 0);
    chk("rst_done", int'(done[0]), 0);
    chk("rst_sclk", int'(sclk[0]), 0);
    chk("rst_sdin", int'(sdin[0]), 0);
    step(); rst_n = 1'b1; step();
    clear_mon();

    // Basic frame, CLK_DIV=2
    start_frame(0, 5'b10110);
    wait_done(0, 1, 100);
    chk("basic_bits",  int'(cap[0][4:0]), int'(5'b10110));
    chk("basic_rises", rises[0], 5);
    chk("basic_busy",  busy_n[0], 22);
    chk("basic_rise0", first_rise[0], 3);
    chk("basic_rise4", last_rise[0], 19);
    chk("basic_done",  done_cyc[0], 23);

    // Start pulse at cycle 8 with different data must be ignored
    step(); clear_mon();
    start_frame(0, 5'b10110);
    repeat (7) step();
    st[0] = 1'b1; dat[0] = 5'b00000; step(); st[0] = 1'b0;
    wait_done(0, 1, 100);
    repeat (10) step();
    chk("busy_bits",   int'(cap[0][4:0]), int'(5'b10110));
    chk("busy_rises",  rises[0], 5);
    chk("busy_ndone",  done_n[0], 1);
    chk("busy_frames", frames[0], 1);
    chk("busy_len",    busy_n[0], 22);

    // Back-to-back with start held high
    clear_mon();
    st[0] = 1'b1; dat[0] = 5'b11111;
    begin
      int k = 0;
      while (!busy[0] && k < 20) begin step(); k++; end
      dat[0] = 5'b00001;
      k = 0;
      while (frames[0] < 2 && k < 100) begin step(); k++; end
      st[0] = 1'b0;
    end
    wait_done(0, 2, 100);
    chk("b2b_rises", rises[0], 10);
    chk("b2b_bits",  int'(cap[0][9:0]), int'(10'b11111_00001));
    chk("b2b_gap",   b2b[0], 1);
    chk("b2b_ndone", done_n[0], 2);
    chk("b2b_busy",  busy_n[0], 44);

    // Asynchronous reset in cycle 10 (LOW phase of bit 2, sdin=1)
    step(); clear_mon();
    start_frame(0, 5'b10110);
    repeat (9) step();
    chk("rst_pre_sdin", int'(sdin[0]), 1);
    chk("rst_pre_busy", int'(busy[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sclk", int'(sclk[0]), 0);
    chk("arst_sdin", int'(sdin[0]), 0);
    chk("arst_busy", int'(busy[0]), 0);
    step(); step(); rst_n = 1'b1;
    repeat (30) step();
    chk("arst_nodone", done_n[0], 0);
    clear_mon();
    start_frame(0, 5'b01011);
    wait_done(0, 1, 100);
    chk("arst_bits",  int'(cap[0][4:0]), int'(5'b01011));
    chk("arst_rises", rises[0], 5);

    // Loopback into backend model, CLK_DIV=4
    clear_mon();
    start_frame(1, 5'b01101);
    wait_done(1, 1, 200);
    repeat (5) step();
    chk("lb_gain_a1", int'(gain_a1), int'(3'b101));
    chk("lb_gain_a2", int'(gain_a2), int'(2'b01));
    chk("lb_edges",   bk_cnt, 5);
    chk("lb_busy",    busy_n[1], 44);
    chk("lb_done",    done_cyc[1], 45);
    chk("lb_rise0",   first_rise[1], 5);

    // Divider corner: CLK_DIV=2 vs 7
    clear_mon();
    st[0] = 1'b1; dat[0] = 5'b10000;
    st[2] = 1'b1; dat[2] = 5'b10000;
    step(); st[0] = 1'b0; st[2] = 1'b0;
    wait_done(2, 1, 300);
    chk("div2_busy",  busy_n[0], 22);
    chk("div7_busy",  busy_n[2], 77);
    chk("div7_rise0", first_rise[2], 8);
    chk("div7_done",  done_cyc[2], 78);
    chk("div7_bits",  int'(cap[2][4:0]), int'(5'b10000));
    chk("div2_hold",  viol[0], 0);
    chk("div7_hold",  viol[2], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
